// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding, default parameters and counter width helper
package fifo_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_PAUSE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    PAUSE = 2'd2
  } arb_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - requester/FIFO handshake bundle around the read arbiter
interface fifo_rd_arbiter_if import fifo_arb_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ
) ();

  logic [N_REQ-1:0] req;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rd_valid;
  logic             busy;

  modport master (
    output req, fifo_empty,
    input  fifo_rd_en, gnt, rd_valid, busy
  );

  modport slave (
    input  req, fifo_empty,
    output fifo_rd_en, gnt, rd_valid, busy
  );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rtl/fifo_rd_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx
);

  logic [IW:0] cand;

  // Walk from the farthest offset down so the candidate closest to ptr is written last.
  always_comb begin
    winner = '0;
    idx    = '0;
    cand   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (req[cand[IW-1:0]]) begin
        winner                 = '0;
        winner[cand[IW-1:0]]   = 1'b1;
        idx                    = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin arbiter sharing one FIFO read port with burst and pause limits
module fifo_rd_arbiter import fifo_arb_pkg::*; #(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int PAUSE_MAX = DEF_PAUSE_MAX
) (
  input  logic             Clk,
  input  logic             Resetn,
  fifo_rd_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = cnt_width(MAX_BURST);
  localparam int PW = cnt_width(PAUSE_MAX);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rd_valid_q, win;
  logic [IW-1:0]    gidx_q, gidx_d, ptr_q, ptr_d, win_idx, ptr_next;
  logic [BW-1:0]    beat_q, beat_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             req_g, rd_en, last_beat, release_g;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (win),
    .idx    (win_idx)
  );

  assign req_g     = bus.req[gidx_q];
  assign rd_en     = (state_q == BURST) && req_g && !bus.fifo_empty;
  assign last_beat = (beat_q == BW'(MAX_BURST - 1));
  assign ptr_next  = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);

  assign bus.fifo_rd_en = rd_en;
  assign bus.gnt        = gnt_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.busy       = (state_q != IDLE);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      beat_q     <= '0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= gnt_q & {N_REQ{rd_en}};
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      pcnt_q     <= pcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    pcnt_d    = pcnt_q;
    release_g = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = BURST;
          gnt_d   = win;
          gidx_d  = win_idx;
          beat_d  = '0;
          pcnt_d  = '0;
        end
      end
      BURST: begin
        if (rd_en) beat_d = beat_q + BW'(1);
        // A last beat coinciding with a req drop falls into this single release.
        if ((rd_en && last_beat) || !req_g) begin
          release_g = 1'b1;
        end else if (bus.fifo_empty) begin
          state_d = PAUSE;
          pcnt_d  = '0;
        end
      end
      PAUSE: begin
        if (req_g && !bus.fifo_empty) begin
          state_d = BURST;
        end else if (!req_g || pcnt_q == PW'(PAUSE_MAX - 1)) begin
          release_g = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (release_g) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = ptr_next;
      beat_d  = '0;
      pcnt_d  = '0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - self-checking bench: vector table, corner sequences, randomized run vs model
module tb_fifo_rd_arbiter;
  import fifo_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 8;
  localparam int PMAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_arbiter_if #(.N_REQ(N)) bus ();

  fifo_rd_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .PAUSE_MAX(PMAX)) dut (
    .Clk    (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fifo_cnt = 0;
  int reads_total = 0;
  logic [3:0] obs_gnt;

  // Grant-session model: who owns the port, reads so far, cycles spent waiting on an empty FIFO.
  int m_owner, m_reads, m_wait, m_ptr;
  logic [3:0] m_rdv;

  typedef struct {
    logic [3:0] req;
    int         words;
    int         wr_cyc;
    int         wr_n;
    int         ncyc;
    int         exp_reads;
    logic [3:0] exp_first;
    logic [3:0] exp_last;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_reads = 0;
    m_wait  = -1;
    m_ptr   = 0;
    m_rdv   = 4'b0;
  endtask

  function automatic logic [3:0] exp_gnt();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
  endfunction

  function automatic logic exp_rd(input logic [3:0] r, input logic e);
    if (m_owner < 0 || m_wait >= 0) return 1'b0;
    return r[m_owner[1:0]] && !e;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic e);
    logic rd;
    logic own_req;
    logic rel;
    int j;
    rd    = exp_rd(r, e);
    m_rdv = rd ? exp_gnt() : 4'b0;
    rel   = 1'b0;
    if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        j = (m_ptr + k) % N;
        if (r[j[1:0]]) m_owner = j;
      end
      m_reads = 0;
      m_wait  = -1;
    end else begin
      own_req = r[m_owner[1:0]];
      if (m_wait < 0) begin
        if (rd) m_reads++;
        if ((rd && m_reads == MAXB) || !own_req) rel = 1'b1;
        else if (e) m_wait = 0;
      end else begin
        if (own_req && !e) m_wait = -1;
        else if (!own_req || m_wait == PMAX - 1) rel = 1'b1;
        else m_wait++;
      end
    end
    if (rel) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  task automatic cycle(input logic [3:0] nreq, input int wr);
    logic [3:0] r;
    logic e, rd;
    @(negedge clk);
    r = bus.req;
    e = bus.fifo_empty;
    rd = bus.fifo_rd_en;
    obs_gnt = bus.gnt;
    chk("gnt", int'(bus.gnt), int'(exp_gnt()));
    chk("busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);
    chk("rd_valid", int'(bus.rd_valid), int'(m_rdv));
    chk("fifo_rd_en", int'(rd), int'(exp_rd(r, e)));
    @(posedge clk);
    #1;
    model_step(r, e);
    if (rd && fifo_cnt > 0) begin
      fifo_cnt--;
      reads_total++;
    end
    fifo_cnt += wr;
    bus.fifo_empty = (fifo_cnt == 0);
    bus.req = nreq;
  endtask

  task automatic do_reset(input int words);
    rst_n = 1'b0;
    bus.req = 4'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fifo_cnt = words;
    bus.fifo_empty = (fifo_cnt == 0);
    reads_total = 0;
  endtask

  initial begin
    vec_t tv;
    logic [3:0] first_g, last_g, nreq;
    int wr;

    bus.req = 4'b0;
    bus.fifo_empty = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #6;
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_rd_valid", int'(bus.rd_valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_rd_en", int'(bus.fifo_rd_en), 0);

    tbl[0] = '{4'b0001, 20, -1, 0, 10, 8, 4'b0001, 4'b0000};
    tbl[1] = '{4'b0100, 3, 4, 2, 16, 5, 4'b0100, 4'b0100};
    tbl[2] = '{4'b0010, 0, -1, 0, 7, 0, 4'b0010, 4'b0000};
    tbl[3] = '{4'b1111, 100, -1, 0, 38, 33, 4'b0001, 4'b0001};

    for (int t = 0; t < 4; t++) begin
      tv = tbl[t];
      do_reset(tv.words);
      bus.req = tv.req;
      first_g = 4'b0;
      last_g  = 4'b0;
      for (int i = 0; i < tv.ncyc; i++) begin
        cycle(tv.req, (i == tv.wr_cyc) ? tv.wr_n : 0);
        if (i == 1) first_g = obs_gnt;
        if (i == tv.ncyc - 1) last_g = obs_gnt;
      end
      chk($sformatf("vec%0d_reads", t), reads_total, tv.exp_reads);
      chk($sformatf("vec%0d_first_gnt", t), int'(first_g), int'(tv.exp_first));
      chk($sformatf("vec%0d_last_gnt", t), int'(last_g), int'(tv.exp_last));
    end

    // Requester 2 drops after five reads; requester 3 must follow after one idle cycle.
    do_reset(50);
    bus.req = 4'b1100;
    for (int i = 0; i < 10; i++) begin
      cycle((i >= 5) ? 4'b1000 : 4'b1100, 0);
      if (i == 6) chk("drop_reads", reads_total, 5);
      if (i == 7) chk("drop_gap_gnt", int'(obs_gnt), 0);
      if (i == 8) chk("drop_next_gnt", int'(obs_gnt), 8);
    end

    // Asynchronous reset in the middle of a burst.
    do_reset(50);
    bus.req = 4'b0001;
    for (int i = 0; i < 5; i++) cycle(4'b0001, 0);
    #2;
    chk("pre_reset_rd_en", int'(bus.fifo_rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("async_gnt", int'(bus.gnt), 0);
    chk("async_rd_valid", int'(bus.rd_valid), 0);
    chk("async_rd_en", int'(bus.fifo_rd_en), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_reads", reads_total, 4);
    bus.req = 4'b1000;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1000, 0);
      if (i == 1) chk("post_reset_gnt", int'(obs_gnt), 8);
    end

    // Randomized traffic against the session model.
    do_reset(0);
    for (int i = 0; i < 400; i++) begin
      nreq = bus.req;
      if ($urandom_range(0, 3) == 0) nreq = 4'($urandom_range(0, 15));
      wr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      if (fifo_cnt > 40) wr = 0;
      cycle(nreq, wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of read requesters sharing one FIFO read port.
REQ-002 Parameter MAX_BURST, default 8, maximum words read per grant.
REQ-003 Parameter PAUSE_MAX, default 4, maximum consecutive cycles a grant is held while the FIFO is empty.
REQ-004 Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-005 Resetn  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N_REQ  per-requester read request, level-sensitive.
REQ-007 fifo_empty  input  1  registered empty flag from the FIFO read side.
REQ-008 fifo_rd_en  output  1  read enable to the FIFO read side.
REQ-009 gnt  output  N_REQ  one-hot grant, registered.
REQ-010 rd_valid  output  N_REQ  one-hot data-valid routing strobe, registered.
REQ-011 busy  output  1  high when state is not IDLE.

Function
REQ-012 The FSM shall have exactly three states: IDLE, BURST and PAUSE.
REQ-013 In IDLE, when any req bit is high, the arbiter shall pick one winner round-robin, register gnt one-hot to it and enter BURST on the next edge; one cycle separates req from gnt.
REQ-014 Round-robin: after a grant to requester k is released, highest priority shall be (k+1) mod N_REQ; after reset it shall be requester 0.
REQ-015 fifo_rd_en shall be combinational: state==BURST AND req[g] AND NOT fifo_empty, where g is the granted index; it shall be 0 in IDLE and PAUSE.
REQ-016 Beat counter (width clog2(MAX_BURST+1)) shall clear on grant and increment on each cycle fifo_rd_en is high.
REQ-017 BURST -> IDLE, releasing gnt, when a read occurs with beat count == MAX_BURST-1 (last beat), or when req[g] is low.
REQ-018 BURST -> PAUSE when req[g] is high, fifo_empty is high and the burst is not complete; the pause counter shall clear.
REQ-019 PAUSE -> BURST when fifo_empty is low and req[g] is high; the beat count shall be preserved.
REQ-020 PAUSE -> IDLE, releasing gnt, when req[g] is low or the pause counter reaches PAUSE_MAX-1; otherwise the pause counter shall increment.
REQ-021 rd_valid shall equal gnt registered and masked by fifo_rd_en, so rd_valid[g] is high exactly one cycle after each read.
REQ-022 On every release, gnt shall be all-zero for at least one IDLE cycle before any new grant.
REQ-023 Simultaneous last beat and req[g] drop shall be a single release; the round-robin pointer shall advance once.
REQ-024 A request that drops before being granted shall have no effect; the arbiter shall never grant a requester whose req is low at the decision edge.

Reset
REQ-025 Resetn low shall immediately force state IDLE, gnt=0, rd_valid=0, busy=0, both counters to 0 and the round-robin pointer to 0, independent of Clk.
REQ-026 Reset asserted mid-burst shall force fifo_rd_en to 0 in the same cycle; no read shall be issued until a fresh grant after Resetn deasserts.

Structure
REQ-027 State encoding, N_REQ/MAX_BURST/PAUSE_MAX defaults and the counter-width function shall reside in the shared package fifo_arb_pkg.
REQ-028 Round-robin selection shall be a separate combinational sub-module rr_pick (inputs req and priority pointer; outputs one-hot winner and its index).

Verification
REQ-029 req=0001, FIFO holding 20 words -> gnt=0001 one cycle later; 8 consecutive fifo_rd_en pulses; release; second grant to requester 0 after a one-cycle gap.
REQ-030 req=1111 held, FIFO never empty -> grants rotate 0,1,2,3,0, each grant covering 8 reads, with rd_valid one-hot matching gnt delayed one cycle.
REQ-031 req=0100, FIFO holding 3 words -> 3 reads, then PAUSE; write 2 words within 2 cycles -> resume BURST, beat count continues at 3, total 5 reads.
REQ-032 req=0010, FIFO empty throughout the grant -> PAUSE for 4 cycles, release, busy=0, zero reads issued.
REQ-033 Requester 2 drops req after 5 reads -> release on that cycle; next grant to requester 3 if its req is high.
REQ-034 Resetn pulsed low asynchronously mid-burst after 4 reads -> gnt, rd_valid and fifo_rd_en are 0 before the next Clk edge; after release req=1000 is granted only after requesters 0..2 are checked, pointer at 0.
